// File: rtl/sensors_scan_ctrl_if.sv
// Shared request/acknowledge sensor bus between the scan sequencer (master) and
// the sensor mux (slave).
interface sensors_scan_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [1:0]            sens_sel;
   logic                  sens_req;
   logic                  sens_ack;
   logic [DATA_WIDTH-1:0] sens_data;

   modport master (output sens_sel, output sens_req, input sens_ack, input sens_data);
   modport slave  (input sens_sel, input sens_req, output sens_ack, output sens_data);
endinterface

// File: rtl/sensors_scan_ctrl.sv
// Polls four distance sensors over a shared req/ack bus, feeds sensors_input and
// registers its height with a valid pulse. Optional macro: CONTINUOUS_SCAN_EN.
module sensors_scan_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   sensors_scan_ctrl_if.master   bus,
   output logic [DATA_WIDTH-1:0] sensor1,
   output logic [DATA_WIDTH-1:0] sensor2,
   output logic [DATA_WIDTH-1:0] sensor3,
   output logic [DATA_WIDTH-1:0] sensor4,
   input  logic [DATA_WIDTH-1:0] height_in,
   output logic [DATA_WIDTH-1:0] height,
   output logic                  height_valid,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StReq, StGap, StSettle, StCapture} state_e;

   state_e                state_q, state_d;
   logic [1:0]            sel_q, sel_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  terr_q, terr_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] height_q;
   logic [DATA_WIDTH-1:0] sens_q [4];
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;

`ifdef CONTINUOUS_SCAN_EN
   logic unused_start;
   assign unused_start = start;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      valid_d = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      unique case (state_q)
         StIdle: begin
`ifdef CONTINUOUS_SCAN_EN
            state_d = StReq;
            sel_d   = 2'd0;
            cnt_d   = 8'd0;
            terr_d  = 1'b0;
`else
            if (start) begin
               state_d = StReq;
               sel_d   = 2'd0;
               cnt_d   = 8'd0;
               terr_d  = 1'b0;
            end
`endif
         end
         StReq: begin
            // Ack has priority over a timeout landing on the same edge.
            if (bus.sens_ack) begin
               wr_en   = 1'b1;
               wr_data = bus.sens_data;
               state_d = (sel_q == 2'd3) ? StSettle : StGap;
            end else if (cnt_q == CNT_LAST) begin
               wr_en   = 1'b1;
               terr_d  = 1'b1;
               state_d = (sel_q == 2'd3) ? StSettle : StGap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            sel_d   = sel_q + 2'd1;
            cnt_d   = 8'd0;
            state_d = StReq;
         end
         StSettle: begin
            // Height is loaded on this edge so it lines up with the valid pulse.
            valid_d = 1'b1;
            state_d = StCapture;
         end
         StCapture: begin
            sel_d = 2'd0;
            cnt_d = 8'd0;
`ifdef CONTINUOUS_SCAN_EN
            terr_d  = 1'b0;
            state_d = StReq;
`else
            state_d = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         sel_q    <= 2'd0;
         cnt_q    <= 8'd0;
         terr_q   <= 1'b0;
         valid_q  <= 1'b0;
         height_q <= '0;
         for (int i = 0; i < 4; i++) sens_q[i] <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
         valid_q <= valid_d;
         if (wr_en) sens_q[sel_q] <= wr_data;
         if (state_q == StSettle) height_q <= height_in;
      end
   end

   assign bus.sens_sel  = sel_q;
   assign bus.sens_req  = (state_q == StReq);
   assign busy          = (state_q != StIdle);
   assign sensor1       = sens_q[0];
   assign sensor2       = sens_q[1];
   assign sensor3       = sens_q[2];
   assign sensor4       = sens_q[3];
   assign height        = height_q;
   assign height_valid  = valid_q;
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_sensors_scan_ctrl.sv
// Directed bench for sensors_scan_ctrl: sensor responder with per-sensor delay and
// a simple averaging stand-in for sensors_input.
module tb_sensors_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] sensor1, sensor2, sensor3, sensor4;
   logic [7:0] height_in, height;
   logic       height_valid, busy, timeout_err;

   int vectors = 0;
   int miscompares = 0;

   int         dly [4];
   logic [7:0] dat [4];
   bit         noack [4];
   int         wcnt = 0;

   // Scan monitor results
   int         reqc [4];
   int         idlebus, nv, first_k;
   logic [7:0] seq, hval;

   always #5 clk = ~clk;

   sensors_scan_ctrl_if #(.DATA_WIDTH(8)) bus ();

   sensors_scan_ctrl #(.DATA_WIDTH(8), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .sensor1      (sensor1),
      .sensor2      (sensor2),
      .sensor3      (sensor3),
      .sensor4      (sensor4),
      .height_in    (height_in),
      .height       (height),
      .height_valid (height_valid),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   // Stand-in for sensors_input: mean of the four readings.
   always_comb
      height_in = 8'((10'(sensor1) + 10'(sensor2) + 10'(sensor3) + 10'(sensor4)) >> 2);

   always @(negedge clk) begin
      if (bus.sens_req) begin
         if (!noack[bus.sens_sel] && wcnt >= dly[bus.sens_sel]) begin
            bus.sens_ack  = 1'b1;
            bus.sens_data = dat[bus.sens_sel];
         end else begin
            bus.sens_ack  = 1'b0;
            bus.sens_data = 8'hEE;
         end
         wcnt++;
      end else begin
         bus.sens_ack  = 1'b0;
         bus.sens_data = 8'hEE;
         wcnt = 0;
      end
   end

   task automatic set_resp(input int d, input logic [7:0] a, b, c, e);
      for (int i = 0; i < 4; i++) begin
         dly[i]   = d;
         noack[i] = 1'b0;
      end
      dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = e;
   endtask

   // Leaves us at the negedge after the edge that sampled start (k = 0).
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic scan_watch();
      int  k;
      logic prev_req;
      k = 0; prev_req = 1'b0; idlebus = 0; nv = 0; first_k = -1; seq = 8'h00; hval = 8'h00;
      for (int i = 0; i < 4; i++) reqc[i] = 0;
      forever begin
         if (bus.sens_req) begin
            reqc[bus.sens_sel]++;
            if (!prev_req) seq = {seq[5:0], bus.sens_sel};
         end else if (busy) begin
            idlebus++;
         end
         if (height_valid) begin
            nv++;
            if (first_k < 0) first_k = k;
            hval = height;
         end
         prev_req = bus.sens_req;
         if (!busy || k >= 60) break;
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      vectors++;
      if (busy) begin
         miscompares++;
         $display("FAIL scan_timeout: busy still %b after %0d cycles, required 0", busy, k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      set_resp(0, 8'd0, 8'd0, 8'd0, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors += 7;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (bus.sens_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus.sens_req); end
      if (bus.sens_sel !== 2'd0) begin miscompares++; $display("FAIL rst_sel: got %0d want 0", bus.sens_sel); end
      if (height !== 8'd0) begin miscompares++; $display("FAIL rst_height: got %0d want 0", height); end
      if (height_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", height_valid); end
      if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
      if ({sensor1, sensor2, sensor3, sensor4} !== 32'd0) begin
         miscompares++; $display("FAIL rst_sensors: got %h want 0", {sensor1, sensor2, sensor3, sensor4});
      end
      rst = 1'b0;
   endtask

   task automatic test_immediate();
      set_resp(0, 8'd40, 8'd40, 8'd40, 8'd40);
      pulse_start();
      scan_watch();
      vectors += 6;
      if (first_k != 8) begin miscompares++; $display("FAIL imm_latency: got %0d want 8", first_k); end
      if (nv != 1) begin miscompares++; $display("FAIL imm_pulses: got %0d want 1", nv); end
      if (hval !== 8'd40) begin miscompares++; $display("FAIL imm_height: got %0d want 40", hval); end
      if ({sensor1, sensor2, sensor3, sensor4} !== {4{8'd40}}) begin
         miscompares++; $display("FAIL imm_sensors: got %h want 28282828", {sensor1, sensor2, sensor3, sensor4});
      end
      if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL imm_terr: got %b want 0", timeout_err); end
      if (height !== 8'd40) begin miscompares++; $display("FAIL imm_height_hold: got %0d want 40", height); end
   endtask

   task automatic test_delayed();
      set_resp(3, 8'd10, 8'd20, 8'd30, 8'd40);
      pulse_start();
      scan_watch();
      vectors += 6;
      if (seq !== 8'h1B) begin miscompares++; $display("FAIL dly_sel_seq: got %h want 1b", seq); end
      if (reqc[0] != 4 || reqc[1] != 4 || reqc[2] != 4 || reqc[3] != 4) begin
         miscompares++;
         $display("FAIL dly_req_cycles: got %0d %0d %0d %0d want 4 4 4 4",
                  reqc[0], reqc[1], reqc[2], reqc[3]);
      end
      if (idlebus != 5) begin miscompares++; $display("FAIL dly_noreq_cycles: got %0d want 5", idlebus); end
      if (first_k != 20) begin miscompares++; $display("FAIL dly_latency: got %0d want 20", first_k); end
      if (hval !== 8'd25) begin miscompares++; $display("FAIL dly_height: got %0d want 25", hval); end
      if (nv != 1) begin miscompares++; $display("FAIL dly_pulses: got %0d want 1", nv); end
   endtask

   task automatic test_timeout();
      set_resp(0, 8'd50, 8'd50, 8'd50, 8'd50);
      noack[2] = 1'b1;
      pulse_start();
      scan_watch();
      vectors += 6;
      if (reqc[2] != 15) begin miscompares++; $display("FAIL to_req_cycles: got %0d want 15", reqc[2]); end
      if (sensor3 !== 8'd0) begin miscompares++; $display("FAIL to_sensor3: got %0d want 0", sensor3); end
      if (sensor4 !== 8'd50) begin miscompares++; $display("FAIL to_sensor4: got %0d want 50", sensor4); end
      if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_terr: got %b want 1", timeout_err); end
      if (first_k != 22 || nv != 1) begin
         miscompares++; $display("FAIL to_valid: got k=%0d n=%0d want k=22 n=1", first_k, nv);
      end
      if (hval !== 8'd37) begin miscompares++; $display("FAIL to_height: got %0d want 37", hval); end
      noack[2] = 1'b0;
      pulse_start();
      vectors++;
      if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", timeout_err); end
      scan_watch();
      vectors += 2;
      if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clean_terr: got %b want 0", timeout_err); end
      if (hval !== 8'd50) begin miscompares++; $display("FAIL to_clean_height: got %0d want 50", hval); end
   endtask

   task automatic test_back_to_back();
      int cnt, k1, k2;
      cnt = 0; k1 = -1; k2 = -1;
      set_resp(0, 8'd40, 8'd40, 8'd40, 8'd40);
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (height_valid) begin
            cnt++;
            if (k1 < 0) k1 = k; else k2 = k;
         end
         if (k == 9) begin
            vectors++;
            if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: got %b want 0", busy); end
         end
      end
      start = 1'b0;
      vectors += 3;
      if (cnt != 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 2", cnt); end
      if (k1 != 8 || k2 != 18) begin
         miscompares++; $display("FAIL b2b_timing: got %0d,%0d want 8,18", k1, k2);
      end
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_final_idle: got %b want 0", busy); end
   endtask

   task automatic test_reset_midscan();
      set_resp(0, 8'd70, 8'd70, 8'd70, 8'd70);
      dly[2] = 5;
      pulse_start();
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      vectors++;
      if (bus.sens_sel !== 2'd2 || bus.sens_req !== 1'b1) begin
         miscompares++; $display("FAIL mid_pre: got sel=%0d req=%b want sel=2 req=1", bus.sens_sel, bus.sens_req);
      end
      #2 rst = 1'b1;
      #1;
      vectors += 6;
      if (sensor1 !== 8'd0 || sensor2 !== 8'd0) begin
         miscompares++; $display("FAIL mid_sensors: got %0d %0d want 0 0", sensor1, sensor2);
      end
      if (bus.sens_sel !== 2'd0) begin miscompares++; $display("FAIL mid_sel: got %0d want 0", bus.sens_sel); end
      if (bus.sens_req !== 1'b0) begin miscompares++; $display("FAIL mid_req: got %b want 0", bus.sens_req); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (height !== 8'd0) begin miscompares++; $display("FAIL mid_height: got %0d want 0", height); end
      if (height_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", height_valid); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dly[2] = 0;
      pulse_start();
      scan_watch();
      vectors += 2;
      if (first_k != 8 || nv != 1) begin
         miscompares++; $display("FAIL mid_resume_valid: got k=%0d n=%0d want k=8 n=1", first_k, nv);
      end
      if (hval !== 8'd70) begin miscompares++; $display("FAIL mid_resume_height: got %0d want 70", hval); end
   endtask

   task automatic test_continuous();
      int cnt, prev_k, bad_gap, idle_seen;
      cnt = 0; prev_k = -1; bad_gap = 0; idle_seen = 0;
      set_resp(0, 8'd60, 8'd60, 8'd60, 8'd60);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         start = k[0];
         if (!busy) idle_seen++;
         if (height_valid) begin
            cnt++;
            if (prev_k < 0) begin
               if (k != 9) bad_gap++;
            end else if (k - prev_k != 9) begin
               bad_gap++;
            end
            prev_k = k;
            vectors++;
            if (height !== 8'd60) begin miscompares++; $display("FAIL cont_height: got %0d want 60", height); end
         end
      end
      vectors += 3;
      if (cnt != 4) begin miscompares++; $display("FAIL cont_pulses: got %0d want 4", cnt); end
      if (bad_gap != 0) begin miscompares++; $display("FAIL cont_period: got %0d bad intervals want 0", bad_gap); end
      if (idle_seen != 0) begin miscompares++; $display("FAIL cont_busy: got %0d idle cycles want 0", idle_seen); end
   endtask

   initial begin
      test_reset();
`ifdef CONTINUOUS_SCAN_EN
      test_continuous();
`else
      test_immediate();
      test_delayed();
      test_timeout();
      test_back_to_back();
      test_reset_midscan();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sensors_scan_ctrl.md
Name: sensors_scan_ctrl

Overview:
- Sequencer in front of the combinational `sensors_input` height block.
- Polls the four distance sensors one at a time over a shared request/acknowledge sensor bus and holds the four readings in registers.
- Drives the held readings into `sensors_input`, registers the resulting height and flags it with a one-cycle valid pulse for the drop logic downstream.
- Also reports a sensor timeout error.

Parameters:
- DATA_WIDTH, 8, width of each sensor reading and of height.
- TIMEOUT, 15, maximum request cycles per sensor before that read is abandoned (legal range 2..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one full scan; sampled only in IDLE.
- sens_sel  out  2  index of the sensor being read (0..3 = sensor1..sensor4).
- sens_req  out  1  read request on the shared sensor bus.
- sens_ack  in  1  sensor bus acknowledge; sens_data is valid when sens_ack is high.
- sens_data  in  DATA_WIDTH  reading returned by the selected sensor.
- sensor1, sensor2, sensor3, sensor4  out  DATA_WIDTH  registered readings, wired to the matching `sensors_input` inputs.
- height_in  in  DATA_WIDTH  height output of `sensors_input`.
- height  out  DATA_WIDTH  registered height of the last completed scan.
- height_valid  out  1  one-cycle pulse when height updates.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky flag: at least one sensor timed out in the current or last scan.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - sens_sel, sens_req, sensor1..4, height, height_valid, busy, timeout_err and the timeout counter all = 0.
  - Reset mid-scan aborts the scan; no valid pulse is produced.
- States: IDLE, REQ, GAP, SETTLE, CAPTURE.
- IDLE:
  - start=1 at an edge -> REQ with sens_sel=0, timeout_err cleared, counter=0.
- REQ:
  - sens_req=1 (combinational from state); sens_sel stable for the whole state.
  - Each edge with sens_ack=1: store sens_data into sensor[sens_sel].
    - sens_sel<3 -> GAP.
    - sens_sel=3 -> SETTLE.
  - Each edge with sens_ack=0: counter+1.
    - When the counter reaches TIMEOUT-1 (TIMEOUT request cycles with no ack): store 0 into sensor[sens_sel], set timeout_err=1, then advance exactly as for an ack.
    - If ack and the timeout coincide on the same edge, the ack wins and the data is stored.
- GAP:
  - One cycle with sens_req=0 (bus turnaround).
  - Increment sens_sel, counter=0, -> REQ.
- SETTLE:
  - One cycle so `sensors_input` sees stable, fully updated inputs.
  - -> CAPTURE.
- CAPTURE:
  - height<=height_in and height_valid=1 for exactly this cycle.
  - -> IDLE; sens_sel returns to 0.
- Latency with ack in the first request cycle of every sensor: start sampled at edge 0, height_valid high in the cycle after edge 8.
- busy is high from the edge after start is sampled through CAPTURE.
- Timing and hold rules:
  - start while busy is ignored (not queued).
  - sens_ack outside REQ is ignored.
  - sensor1..4 hold their values between scans; only the selected sensor register changes in REQ.
  - height holds its value until the next CAPTURE.
  - timeout_err persists until the next accepted start or reset.

Optional Feature:
- CONTINUOUS_SCAN_EN
  - Defined: after CAPTURE the FSM goes directly to REQ with sens_sel=0 instead of IDLE; the first scan begins automatically on the first edge after reset release; the start input is ignored; timeout_err clears at each scan start; busy stays high continuously.
  - Undefined: single-shot operation as described above.

Test Plan:
- Immediate ack, sens_data = 40,40,40,40, start pulse -> sensor1..4 = 40, height=40, height_valid exactly one cycle, 8 edges after start, busy low afterwards, timeout_err=0.
- Ack delayed 3 cycles per sensor, data 10,20,30,40 -> sens_req stays high through each wait, sens_sel steps 0,1,2,3 with one-cycle gaps; height equals the `sensors_input` reference output for (10,20,30,40).
- No ack for sensor3 (sel=2) with TIMEOUT=15, others give 50 -> sensor3=0 after 15 request cycles, timeout_err=1, scan completes with a valid pulse; the next start clears timeout_err.
- start re-asserted every cycle during a scan -> exactly one valid pulse per scan; a new scan begins only after returning to IDLE.
- rst asserted while in REQ with sel=2 -> all outputs 0 immediately (asynchronous), no valid pulse; a subsequent start completes normally.
- With CONTINUOUS_SCAN_EN and constant ack, data 60 -> height_valid pulses every 9 cycles with height=60, start has no effect.
